control_niveles_cubos: RTL and testbench
========================================

# control_niveles_cubos

Game-flow controller for Falling Cubes that runs a configurable number of timed levels. It replaces the single-lapse start/finish sequencer with a level counter, an internal per-level tick counter, optional pause and a forced end-of-game input. It sits between the start/pause button debouncers, the one-second tick generator and the cube spawner/score/display logic.

## Interface
- NUM_NIVELES, default 4: number of levels per game (≥1).
- ANCHO_TICKS, default 8: width of the per-level tick counter and of `tiempo_restante`.
- TICKS_NIVEL, default 30: ticks per level (1 ≤ TICKS_NIVEL ≤ 2^ANCHO_TICKS).
- ANCHO_NIVEL (derived): $clog2(NUM_NIVELES), minimum 1.

Ports:
- clk  in  1  system clock; one clock domain only.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a game from E_INICIO.
- pausa  in  1  one-cycle pulse; toggles pause while a game runs.
- tick  in  1  one-cycle enable marking one time unit (e.g. 1 s).
- fin_forzado  in  1  level-sensitive; ends the game immediately (e.g. player collision).
- activar_timer  out  1  registered one-cycle pulse at game start and at each level change.
- habilitar_cubos  out  1  high while in E_JUGANDO.
- pausado  out  1  high while in E_PAUSA.
- nivel  out  ANCHO_NIVEL  current level, 0-based.
- tiempo_restante  out  ANCHO_TICKS  TICKS_NIVEL-1-cont_ticks while playing or paused, else 0.
- pulsoFinalJuego  out  1  high for exactly one cycle in E_FINAL.

## Operation
- States: E_INICIO, E_JUGANDO, E_PAUSA, E_FINAL. Unencoded values go to E_INICIO.
- E_INICIO: `start` moves to E_JUGANDO. It also clears `cont_ticks` and `nivel` to 0 and schedules an `activar_timer` pulse. `nivel` keeps its last value in E_INICIO until the next start.
- E_JUGANDO: each `tick` increments `cont_ticks`.
  - On a tick with `cont_ticks == TICKS_NIVEL-1` and `nivel < NUM_NIVELES-1`: `nivel` increments, `cont_ticks` clears and an `activar_timer` pulse is scheduled.
  - On a tick with `cont_ticks == TICKS_NIVEL-1` and `nivel == NUM_NIVELES-1`: move to E_FINAL.
  - `pausa` moves to E_PAUSA.
- E_PAUSA: `tick` is ignored and the counters hold. `pausa` returns to E_JUGANDO with no timer pulse.
- E_FINAL: lasts one cycle, then goes unconditionally to E_INICIO. All inputs are ignored.
- Priority in E_JUGANDO and E_PAUSA: `fin_forzado` first (goes to E_FINAL, counters hold), then `tick`, then `pausa`.
- Same-cycle `tick` and `pausa` in E_JUGANDO: the tick is applied first.
  - If that tick ends the game, the game ends and `pausa` is dropped.
  - Otherwise the counters update and the state goes to E_PAUSA.
- `start` is ignored outside E_INICIO. `fin_forzado` in E_INICIO is ignored.
- Counter arithmetic is unsigned. `cont_ticks` never exceeds TICKS_NIVEL-1 and never wraps.

## Timing
- Reset values, all outputs: `activar_timer`=0, `habilitar_cubos`=0, `pausado`=0, `nivel`=0, `tiempo_restante`=0, `pulsoFinalJuego`=0. State resets to E_INICIO and `cont_ticks` to 0.
- A reset in any state (mid-game, paused, E_FINAL) returns to E_INICIO on the next edge, with no `pulsoFinalJuego`.
- Transitions take effect on the clock edge after the triggering input is sampled.
- `activar_timer` is registered. It is high in the cycle after the edge where the transition or level change occurs, which is 2 cycles after the input cycle. It is never high for two consecutive cycles.
- `habilitar_cubos`, `pausado` and `pulsoFinalJuego` are decoded directly from the state register. There is no added latency beyond the state update.
- `nivel` and `tiempo_restante` change on the same edge as the state or counter update.
- Game length without pause or forced end is NUM_NIVELES × TICKS_NIVEL ticks. E_FINAL is entered on the edge after the last tick.

## Configuration
- CONTROL_PAUSA_EN defined: E_PAUSA and the `pausa` handling are compiled in, exactly as described above.
- CONTROL_PAUSA_EN undefined:
  - `pausa` is ignored and E_PAUSA is never reachable.
  - `pausado` is tied to 0.
  - The `pausa` and `pausado` ports remain so the port list is unchanged.
  - All other behaviour is identical.

## Test plan
- Reset, then `start` pulse → `activar_timer` is high exactly 2 cycles after `start`. `habilitar_cubos`=1, `nivel`=0, `tiempo_restante`=29 (defaults).
- Defaults, 30 ticks → `nivel`=1, one `activar_timer` pulse, `tiempo_restante`=29. After 120 total ticks → `pulsoFinalJuego` high for 1 cycle, then E_INICIO with `nivel` held at 3.
- `fin_forzado` asserted at level 1 with `tiempo_restante`=10 → E_FINAL on the next edge, single `pulsoFinalJuego`, no further `activar_timer`.
- With CONTROL_PAUSA_EN: `pausa`, then 5 ticks, then `pausa` → `pausado` high during the gap, `tiempo_restante` unchanged across the pause, no timer pulse on resume. Same-cycle `tick` and `pausa` with `tiempo_restante`=5 → pauses with 4.
- NUM_NIVELES=1, TICKS_NIVEL=1: `start`, then 1 tick → `pulsoFinalJuego` the edge after the tick. `nivel` stays 0 with width 1. A `start` pulse during play is ignored.
- `reset` asserted mid-level 2 while paused → all outputs 0 on the next edge, no `pulsoFinalJuego`. A fresh `start` restarts at level 0.

Source files
------------

// File: rtl/control_niveles_cubos.sv
// Level/tick game-flow controller for Falling Cubes (start, timed levels, pause, forced end).
// Optional pause support is compiled in when CONTROL_PAUSA_EN is defined.
module control_niveles_cubos #(
    parameter  int NUM_NIVELES = 4,
    parameter  int ANCHO_TICKS = 8,
    parameter  int TICKS_NIVEL = 30,
    localparam int ANCHO_NIVEL = (NUM_NIVELES > 1) ? $clog2(NUM_NIVELES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   pausa,
    input  logic                   tick,
    input  logic                   fin_forzado,
    output logic                   activar_timer,
    output logic                   habilitar_cubos,
    output logic                   pausado,
    output logic [ANCHO_NIVEL-1:0] nivel,
    output logic [ANCHO_TICKS-1:0] tiempo_restante,
    output logic                   pulsoFinalJuego
);

    typedef enum logic [1:0] {
        E_INICIO  = 2'd0,
        E_JUGANDO = 2'd1,
        E_PAUSA   = 2'd2,
        E_FINAL   = 2'd3
    } estado_t;

    localparam logic [ANCHO_TICKS-1:0] ULTIMO_TICK  = ANCHO_TICKS'(TICKS_NIVEL - 1);
    localparam logic [ANCHO_NIVEL-1:0] ULTIMO_NIVEL = ANCHO_NIVEL'(NUM_NIVELES - 1);

    estado_t                estado_q;
    logic [ANCHO_TICKS-1:0] cont_ticks_q;
    logic [ANCHO_NIVEL-1:0] nivel_q;
    logic                   pend_timer_q;
    logic                   activar_timer_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q        <= E_INICIO;
            cont_ticks_q    <= '0;
            nivel_q         <= '0;
            pend_timer_q    <= 1'b0;
            activar_timer_q <= 1'b0;
        end else begin
            pend_timer_q    <= 1'b0;
            // The pulse trails its scheduling edge by one cycle; back-to-back requests merge.
            activar_timer_q <= pend_timer_q && !activar_timer_q;
            case (estado_q)
                E_INICIO: begin
                    if (start) begin
                        estado_q     <= E_JUGANDO;
                        cont_ticks_q <= '0;
                        nivel_q      <= '0;
                        pend_timer_q <= 1'b1;
                    end
                end
                E_JUGANDO: begin
                    if (fin_forzado) begin
                        estado_q <= E_FINAL;
                    end else if (tick && (cont_ticks_q == ULTIMO_TICK)) begin
                        if (nivel_q == ULTIMO_NIVEL) begin
                            estado_q <= E_FINAL;
                        end else begin
                            nivel_q      <= nivel_q + ANCHO_NIVEL'(1);
                            cont_ticks_q <= '0;
                            pend_timer_q <= 1'b1;
`ifdef CONTROL_PAUSA_EN
                            if (pausa) estado_q <= E_PAUSA;
`endif
                        end
                    end else begin
                        if (tick) cont_ticks_q <= cont_ticks_q + ANCHO_TICKS'(1);
`ifdef CONTROL_PAUSA_EN
                        if (pausa) estado_q <= E_PAUSA;
`endif
                    end
                end
`ifdef CONTROL_PAUSA_EN
                E_PAUSA: begin
                    if (fin_forzado)  estado_q <= E_FINAL;
                    else if (pausa)   estado_q <= E_JUGANDO;
                end
`endif
                E_FINAL:  estado_q <= E_INICIO;
                default:  estado_q <= E_INICIO;
            endcase
        end
    end

    assign activar_timer   = activar_timer_q;
    assign habilitar_cubos = (estado_q == E_JUGANDO);
    assign pulsoFinalJuego = (estado_q == E_FINAL);
    assign nivel           = nivel_q;
    assign tiempo_restante = ((estado_q == E_JUGANDO) || (estado_q == E_PAUSA))
                             ? (ULTIMO_TICK - cont_ticks_q) : '0;

`ifdef CONTROL_PAUSA_EN
    assign pausado = (estado_q == E_PAUSA);
`else
    logic unused_pausa;
    assign unused_pausa = pausa;
    assign pausado      = 1'b0;
`endif

endmodule

// File: tb/tb_control_niveles_cubos.sv
// Bench for control_niveles_cubos: default instance plus a 1-level/1-tick instance,
// vector table, directed corner sequences and random stimulus against an elapsed-tick model.
module tb_control_niveles_cubos;

    localparam int N0 = 4, T0 = 30, N1 = 1, T1 = 1;
`ifdef CONTROL_PAUSA_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0, pausa = 1'b0, tick = 1'b0, fin_forzado = 1'b0;
    logic at0, hab0, pau0, fin0, at1, hab1, pau1, fin1;
    logic [1:0] niv0;
    logic [0:0] niv1;
    logic [7:0] tr0, tr1;

    always #5 clk = ~clk;

    control_niveles_cubos #(.NUM_NIVELES(N0), .ANCHO_TICKS(8), .TICKS_NIVEL(T0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .pausa(pausa), .tick(tick),
        .fin_forzado(fin_forzado), .activar_timer(at0), .habilitar_cubos(hab0),
        .pausado(pau0), .nivel(niv0), .tiempo_restante(tr0), .pulsoFinalJuego(fin0));

    control_niveles_cubos #(.NUM_NIVELES(N1), .ANCHO_TICKS(8), .TICKS_NIVEL(T1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .pausa(pausa), .tick(tick),
        .fin_forzado(fin_forzado), .activar_timer(at1), .habilitar_cubos(hab1),
        .pausado(pau1), .nivel(niv1), .tiempo_restante(tr1), .pulsoFinalJuego(fin1));

    int n_cmp = 0, n_bad = 0, cyc_n = 0;
    int tim_cnt0 = 0, tim_cnt1 = 0;

    // Reference model: a game is just a count of elapsed ticks plus a mode.
    localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_FINAL = 3;
    int m_mode[2] = '{M_IDLE, M_IDLE};
    int m_el[2]   = '{0, 0};
    bit m_req[2]  = '{1'b0, 1'b0};
    bit m_tim[2]  = '{1'b0, 1'b0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc_n, act, exp);
        end
    endtask

    function automatic void model_step(input int d, input int n, input int t,
                                       input bit r, input bit s, input bit p,
                                       input bit tk, input bit f);
        bit req = 1'b0;
        bit nt  = m_req[d] && !m_tim[d];
        if (r) begin
            m_mode[d] = M_IDLE; m_el[d] = 0; nt = 1'b0;
        end else begin
            case (m_mode[d])
                M_IDLE: if (s) begin m_mode[d] = M_PLAY; m_el[d] = 0; req = 1'b1; end
                M_PLAY: begin
                    if (f) m_mode[d] = M_FINAL;
                    else if (tk && m_el[d] == n * t - 1) m_mode[d] = M_FINAL;
                    else begin
                        if (tk) begin
                            m_el[d]++;
                            if (m_el[d] % t == 0) req = 1'b1;
                        end
                        if (p && PAUSE_EN) m_mode[d] = M_PAUSE;
                    end
                end
                M_PAUSE: begin
                    if (f) m_mode[d] = M_FINAL;
                    else if (p) m_mode[d] = M_PLAY;
                end
                default: m_mode[d] = M_IDLE;
            endcase
        end
        m_tim[d] = nt;
        m_req[d] = req;
    endfunction

    function automatic logic [31:0] model_vec(input int d, input int t);
        logic [7:0] tr = 8'd0;
        if (m_mode[d] == M_PLAY || m_mode[d] == M_PAUSE) tr = 8'(t - 1 - (m_el[d] % t));
        return {12'd0, m_tim[d], m_mode[d] == M_PLAY, m_mode[d] == M_PAUSE,
                m_mode[d] == M_FINAL, 8'(m_el[d] / t), tr};
    endfunction

    task automatic cyc(input bit r, input bit s, input bit p, input bit tk, input bit f);
        reset = r; start = s; pausa = p; tick = tk; fin_forzado = f;
        @(posedge clk);
        model_step(0, N0, T0, r, s, p, tk, f);
        model_step(1, N1, T1, r, s, p, tk, f);
        @(negedge clk);
        cyc_n++;
        if (at0) tim_cnt0++;
        if (at1) tim_cnt1++;
        chk("model0", {12'd0, at0, hab0, pau0, fin0, 6'd0, niv0, tr0}, model_vec(0, T0));
        chk("model1", {12'd0, at1, hab1, pau1, fin1, 7'd0, niv1, tr1}, model_vec(1, T1));
    endtask

    typedef struct packed {
        bit r, s, p, t, f;
        bit e_tim, e_hab, e_fin;
        logic [1:0] e_niv;
        logic [7:0] e_tr;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd29};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd29};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd28};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd27};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'd0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd29};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd29};

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].t, tbl[i].f);
            chk($sformatf("vec%0d", i), {at0, hab0, fin0, niv0, tr0},
                {tbl[i].e_tim, tbl[i].e_hab, tbl[i].e_fin, tbl[i].e_niv, tbl[i].e_tr});
        end

        // Full game: level change after 30 ticks, end after 120.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        tim_cnt0 = 0;
        for (int i = 0; i < 30; i++) cyc(0, 0, 0, 1, 0);
        chk("lvl1_nivel", niv0, 1);
        chk("lvl1_tiempo", tr0, 29);
        cyc(0, 0, 0, 0, 0);
        chk("lvl1_timers", tim_cnt0, 2);
        for (int i = 0; i < 89; i++) cyc(0, 0, 0, 1, 0);
        chk("end_fin_early", fin0, 0);
        chk("end_tiempo_last", tr0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("end_fin", fin0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("end_fin_once", fin0, 0);
        chk("end_hab", hab0, 0);
        chk("end_nivel_hold", niv0, 3);

        // Forced end at level 1 with 10 remaining.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 49; i++) cyc(0, 0, 0, 1, 0);
        chk("forz_tiempo", tr0, 10);
        chk("forz_nivel", niv0, 1);
        tim_cnt0 = 0;
        cyc(0, 0, 0, 0, 1);
        chk("forz_fin", fin0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("forz_fin_once", fin0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
        chk("forz_no_timer", tim_cnt0, 0);
        chk("forz_nivel_hold", niv0, 1);

        // Pause across ticks, then same-cycle tick+pausa.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        chk("pausa_flag", pau0, PAUSE_EN);
        chk("pausa_tiempo", tr0, 26);
        tim_cnt0 = 0;
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
        chk("pausa_hold", tr0, PAUSE_EN ? 26 : 21);
        cyc(0, 0, 1, 0, 0);
        chk("resume_flag", pau0, 0);
        chk("resume_hab", hab0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("resume_no_timer", tim_cnt0, 0);
        for (int i = 0; i < (PAUSE_EN ? 21 : 16); i++) cyc(0, 0, 0, 1, 0);
        chk("tp_before", tr0, 5);
        cyc(0, 0, 1, 1, 0);
        chk("tp_tiempo", tr0, 4);
        chk("tp_pausado", pau0, PAUSE_EN);

        // Reset mid-level 2 (paused when pause is built in).
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 63; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        chk("l2_nivel", niv0, 2);
        chk("l2_pausado", pau0, PAUSE_EN);
        cyc(1, 0, 0, 0, 0);
        chk("rst_outputs", {at0, hab0, pau0, fin0, niv0, tr0}, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_no_fin", fin0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("restart", {hab0, niv0, tr0}, {1'b1, 2'd0, 8'd29});

        // Single-level, single-tick instance.
        cyc(1, 0, 0, 0, 0);
        tim_cnt1 = 0;
        cyc(0, 1, 0, 0, 0);
        chk("s_hab", {hab1, niv1, tr1}, {1'b1, 1'b0, 8'd0});
        cyc(0, 1, 0, 0, 0);
        chk("s_restart_ign", {hab1, fin1}, 2'b10);
        cyc(0, 0, 0, 1, 0);
        chk("s_fin", {fin1, niv1}, 2'b10);
        cyc(0, 0, 0, 0, 0);
        chk("s_idle", {fin1, hab1}, 2'b00);
        chk("s_timers", tim_cnt1, 1);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(199) == 0, $urandom_range(15) == 0, $urandom_range(7) == 0,
                $urandom_range(2) == 0, $urandom_range(59) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
